// File: rtl/vga_scanout_pkg.sv
// rtl/vga_scanout_pkg.sv - shared timing defaults, function codes and address packing for vga_scanout
package vga_scanout_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int CNT_W   = 11;
    localparam int ADDR_W  = 22;
    localparam int ROW_MSB = 21;
    localparam int COL_MSB = 10;

    typedef enum logic [1:0] {
        FUNC_VRAM = 2'd0,
        FUNC_GPU2 = 2'd1,
        FUNC_GPU3 = 2'd2,
        FUNC_RSVD = 2'd3
    } func_e;

    // Per-pixel flags carried alongside the color through the fetch latency.
    typedef struct packed {
        logic origin;
        logic vsync;
        logic hsync;
        logic active;
    } raster_flags_t;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [CNT_W-1:0] row,
                                                     input logic [CNT_W-1:0] col);
        return {row, col};
    endfunction

    function automatic logic [CNT_W-1:0] addr_row(input logic [ADDR_W-1:0] addr);
        return addr[ROW_MSB:COL_MSB+1];
    endfunction

    function automatic logic [CNT_W-1:0] addr_col(input logic [ADDR_W-1:0] addr);
        return addr[COL_MSB:0];
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - WIDTH x DEPTH shift register with synchronous active-low clear
module vga_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA raster timing, pixel address issue and latency-aligned pin output
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   LATENCY  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        func_request,
    input  logic [2:0]        display_color,
    output logic [ADDR_W-1:0] display_addr,
    output logic [1:0]        current_function,
    output logic              hsync,
    output logic              vsync,
    output logic [2:0]        vga_color,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("vga_scanout: LATENCY must be within 1..4");
    end
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
        $error("vga_scanout: H_TOTAL and V_TOTAL must not exceed 2048");
    end

    // Compare in 12 bits so a sync window ending exactly at 2048 still works.
    localparam logic [CNT_W-1:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [CNT_W:0]   H_ACT    = 12'(H_ACTIVE);
    localparam logic [CNT_W:0]   V_ACT    = 12'(V_ACTIVE);
    localparam logic [CNT_W:0]   HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0]   HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0]   VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]  h_q, h_d;
    logic [CNT_W-1:0]  v_q, v_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        func_q, func_d;
    logic              h_last;
    logic              v_last;
    logic              active_d;

    raster_flags_t     flags_now;
    raster_flags_t     flags_out;

    always_comb begin
        h_last   = (h_q == H_LAST);
        v_last   = (v_q == V_LAST);
        h_d      = h_q + 11'd1;
        v_d      = v_q;
        func_d   = func_q;
        if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + 11'd1;
        end
        // Source switches only on the frame wrap edge, and never to the reserved code.
        if (h_last && v_last && func_request != FUNC_RSVD) begin
            func_d = func_request;
        end
        active_d = ({1'b0, h_d} < H_ACT) && ({1'b0, v_d} < V_ACT);
        addr_d   = active_d ? pack_addr(v_d, h_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q    <= '0;
            v_q    <= '0;
            addr_q <= '0;
            func_q <= FUNC_VRAM;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            addr_q <= addr_d;
            func_q <= func_d;
        end
    end

    always_comb begin
        flags_now.active = ({1'b0, h_q} < H_ACT) && ({1'b0, v_q} < V_ACT);
        flags_now.hsync  = ({1'b0, h_q} >= HS_START) && ({1'b0, h_q} < HS_END);
        flags_now.vsync  = ({1'b0, v_q} >= VS_START) && ({1'b0, v_q} < VS_END);
        flags_now.origin = (h_q == '0) && (v_q == '0);
    end

    vga_delay_line #(
        .WIDTH ($bits(raster_flags_t)),
        .DEPTH (LATENCY)
    ) u_flag_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (flags_now),
        .data_o (flags_out)
    );

    assign display_addr     = addr_q;
    assign current_function = func_q;
    assign vga_color        = flags_out.active ? display_color : 3'd0;
    assign hsync            = flags_out.hsync ? SYNC_POL : ~SYNC_POL;
    assign vsync            = flags_out.vsync ? SYNC_POL : ~SYNC_POL;
    assign frame_start      = flags_out.origin;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - directed bench for vga_scanout on a 16x8 raster with latency 2
module tb_vga_scanout;

    logic        clk;
    logic        rst_n;
    logic [1:0]  func_request;
    logic [2:0]  display_color;
    logic [21:0] display_addr;
    logic [1:0]  current_function;
    logic        hsync;
    logic        vsync;
    logic [2:0]  vga_color;
    logic        frame_start;

    logic [2:0]  col_d1;
    logic [2:0]  col_d2;

    int n_checks;
    int n_fail;

    vga_scanout #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .SYNC_POL (1'b0),
        .LATENCY  (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .func_request     (func_request),
        .display_color    (display_color),
        .display_addr     (display_addr),
        .current_function (current_function),
        .hsync            (hsync),
        .vsync            (vsync),
        .vga_color        (vga_color),
        .frame_start      (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel source: returns the low column bits of the address issued two clocks earlier.
    always @(posedge clk) begin
        col_d1 <= display_addr[2:0];
        col_d2 <= col_d1;
    end
    assign display_color = col_d2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"},  32'(display_addr), 32'd0);
        check({tag, "_color"}, 32'(vga_color), 32'd0);
        check({tag, "_hsync"}, 32'(hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_fs"},    32'(frame_start), 32'd0);
        check({tag, "_func"},  32'(current_function), 32'd0);
    endtask

    initial begin
        int t;
        int line;
        int col;
        int td;
        logic [31:0] exp_addr;
        logic [31:0] exp_color;
        logic [31:0] exp_hs;
        logic [31:0] exp_vs;
        logic [31:0] exp_fs;
        logic [31:0] exp_func;

        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        func_request = 2'd0;
        col_d1       = 3'd0;
        col_d2       = 3'd0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        for (int cyc = 0; cyc <= 306; cyc++) begin
            if (cyc > 0) @(negedge clk);

            t    = cyc % 128;
            line = t / 16;
            col  = t % 16;
            exp_addr = (col < 8 && line < 4) ? 32'((line << 11) | col) : 32'd0;

            exp_color = 32'd0;
            exp_vs    = 32'd1;
            exp_fs    = 32'd0;
            if (cyc >= 2) begin
                td = (cyc - 2) % 128;
                if ((td % 16) < 8 && (td / 16) < 4) exp_color = 32'((td % 16) & 7);
                if ((td / 16) == 5 || (td / 16) == 6) exp_vs = 32'd0;
                if (td == 0) exp_fs = 32'd1;
            end
            exp_hs   = ((cyc % 16) >= 12 && (cyc % 16) <= 14) ? 32'd0 : 32'd1;
            exp_func = (cyc >= 128) ? 32'd1 : 32'd0;

            check($sformatf("addr_c%0d", cyc),  32'(display_addr), exp_addr);
            check($sformatf("color_c%0d", cyc), 32'(vga_color), exp_color);
            check($sformatf("hsync_c%0d", cyc), 32'(hsync), exp_hs);
            check($sformatf("vsync_c%0d", cyc), 32'(vsync), exp_vs);
            check($sformatf("fs_c%0d", cyc),    32'(frame_start), exp_fs);
            check($sformatf("func_c%0d", cyc),  32'(current_function), exp_func);

            if (cyc == 20)  func_request = 2'd1;
            if (cyc == 200) func_request = 2'd3;
        end

        // Cycle 50 of the third frame: one-clock reset pulse.
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("midreset");
        rst_n = 1'b1;

        @(negedge clk);
        check("mid_r1_addr",  32'(display_addr), 32'd1);
        check("mid_r1_fs",    32'(frame_start), 32'd0);
        check("mid_r1_color", 32'(vga_color), 32'd0);
        @(negedge clk);
        check("mid_r2_addr",  32'(display_addr), 32'd2);
        check("mid_r2_fs",    32'(frame_start), 32'd1);
        check("mid_r2_color", 32'(vga_color), 32'd0);
        @(negedge clk);
        check("mid_r3_fs",    32'(frame_start), 32'd0);
        check("mid_r3_color", 32'(vga_color), 32'd1);
        check("mid_r3_func",  32'(current_function), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
